// File: rtl/param_queue_flags.sv
// ---------------------------------------------------------------------------
// param_queue_flags
//   Single-clock FIFO queue with occupancy status and sticky error flags.
//
//   Parameters
//     WIDTH      data word width (>= 1)
//     DEPTH      storage entries (power of two, >= 4)
//     AF_THRESH  almost_full asserts when count >= AF_THRESH
//     AE_THRESH  almost_empty asserts when count <= AE_THRESH
//     FWFT       0: registered read (data_out loads on pop, 1-cycle latency)
//                1: first-word-fall-through (data_out shows head, 0 when empty)
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     data_in, enqueue      write data / write request
//     dequeue               read/pop request
//     flush                 synchronous discard of all stored entries
//     clear_err             synchronous clear of overflow/underflow
//     data_out              read data
//     count                 stored entries, 0..DEPTH
//     full, empty           count == DEPTH / count == 0
//     almost_full/empty     threshold status
//     overflow, underflow   sticky error flags
// ---------------------------------------------------------------------------
module param_queue_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     enqueue,
  input  logic                     dequeue,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL    = CW'(AE_THRESH);

  // Storage is intentionally not reset; the read path never exposes an
  // entry that has not been written since the last reset/flush.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          is_full, is_empty;
  logic          deq_ok, enq_ok;
  logic          ovf_event, unf_event;

  assign is_full  = (count_q == DEPTH_LVL);
  assign is_empty = (count_q == '0);

  // Flush overrides both requests. A full queue still accepts a write when
  // a pop is accepted in the same cycle, since the slot frees at the edge.
  always_comb begin
    deq_ok    = dequeue && !is_empty && !flush;
    enq_ok    = enqueue && (!is_full || deq_ok) && !flush;
    ovf_event = enqueue && is_full && !deq_ok && !flush;
    unf_event = dequeue && is_empty && !flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (enq_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq_ok, deq_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle as clear_err takes priority.
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_event) overflow_d  = 1'b1;
    if (unf_event) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is visible combinationally; zero when nothing is stored.
      always_comb begin
        data_out = '0;
        if (!is_empty) data_out = mem_q[rd_ptr_q];
      end
    end else begin : g_reg
      logic [WIDTH-1:0] data_out_q, data_out_d;

      always_comb begin
        data_out_d = data_out_q;
        if (deq_ok) data_out_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out_q <= '0;
        else        data_out_q <= data_out_d;
      end

      assign data_out = data_out_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_queue_flags.sv
module tb_param_queue_flags;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         enqueue, dequeue, flush, clear_err;

  logic [W-1:0] dout0, dout1;
  logic [4:0]   cnt0, cnt1;
  logic         full0, empty0, af0, ae0, ovf0, unf0;
  logic         full1, empty1, af1, ae1, ovf1, unf1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_queue_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enqueue(enqueue), .dequeue(dequeue),
    .flush(flush), .clear_err(clear_err), .data_out(dout0), .count(cnt0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0));

  param_queue_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enqueue(enqueue), .dequeue(dequeue),
    .flush(flush), .clear_err(clear_err), .data_out(dout1), .count(cnt1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1));

  typedef struct {
    logic       enq, deq, fl, clr;
    logic [7:0] din;
    int         cnt;
    logic       full, empty, af, ae, ovf, unf;
    logic [7:0] d0, d1;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic enq, logic deq, logic fl, logic clr, logic [7:0] din,
                              int cnt, logic f, logic e, logic af, logic ae,
                              logic ovf, logic unf, logic [7:0] d0, logic [7:0] d1);
    vec_t v;
    v.enq = enq; v.deq = deq; v.fl = fl; v.clr = clr; v.din = din;
    v.cnt = cnt; v.full = f; v.empty = e; v.af = af; v.ae = ae;
    v.ovf = ovf; v.unf = unf; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Status shared by both instances, plus each instance's data_out.
  task automatic chk_all(input string tag, input int cnt, input logic f, input logic e,
                         input logic af, input logic ae, input logic ovf, input logic unf,
                         input logic [7:0] d0, input logic [7:0] d1);
    chk({tag, " count"},     32'(cnt0), 32'(cnt));
    chk({tag, " count_fw"},  32'(cnt1), 32'(cnt));
    chk({tag, " full"},      32'(full0), 32'(f));
    chk({tag, " empty"},     32'(empty0), 32'(e));
    chk({tag, " afull"},     32'(af0), 32'(af));
    chk({tag, " aempty"},    32'(ae0), 32'(ae));
    chk({tag, " overflow"},  32'(ovf0), 32'(ovf));
    chk({tag, " underflow"}, 32'(unf0), 32'(unf));
    chk({tag, " unf_fw"},    32'(unf1), 32'(unf));
    chk({tag, " dout_reg"},  32'(dout0), 32'(d0));
    chk({tag, " dout_fwft"}, 32'(dout1), 32'(d1));
  endtask

  // Drive one cycle of inputs at the falling edge; sample 1 time unit after
  // the following rising edge.
  task automatic cyc(input logic enq, input logic deq, input logic fl, input logic clr,
                     input logic [7:0] din);
    @(negedge clk);
    enqueue = enq; dequeue = deq; flush = fl; clear_err = clr; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; data_in = '0; enqueue = 0; dequeue = 0; flush = 0; clear_err = 0;

    //                enq deq fl clr din    cnt f e af ae ov un d0     d1
    tbl[0]  = mk(1, 0, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h11);
    tbl[1]  = mk(1, 0, 0, 0, 8'h22, 2, 0, 0, 0, 1, 0, 0, 8'h00, 8'h11);
    tbl[2]  = mk(1, 0, 0, 0, 8'h33, 3, 0, 0, 0, 0, 0, 0, 8'h00, 8'h11);
    tbl[3]  = mk(0, 1, 0, 0, 8'h00, 2, 0, 0, 0, 1, 0, 0, 8'h11, 8'h22);
    tbl[4]  = mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h22, 8'h33);
    tbl[5]  = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h33, 8'h00);
    tbl[6]  = mk(1, 1, 0, 0, 8'h77, 1, 0, 0, 0, 1, 0, 1, 8'h33, 8'h77);
    tbl[7]  = mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h33, 8'h77);
    tbl[8]  = mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h77, 8'h00);
    tbl[9]  = mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h77, 8'h00);
    tbl[10] = mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h77, 8'h00);
    tbl[11] = mk(1, 0, 0, 0, 8'h41, 1, 0, 0, 0, 1, 0, 0, 8'h77, 8'h41);
    tbl[12] = mk(1, 0, 0, 0, 8'h42, 2, 0, 0, 0, 1, 0, 0, 8'h77, 8'h41);
    tbl[13] = mk(1, 0, 0, 0, 8'h43, 3, 0, 0, 0, 0, 0, 0, 8'h77, 8'h41);
    tbl[14] = mk(1, 0, 0, 0, 8'h44, 4, 0, 0, 0, 0, 0, 0, 8'h77, 8'h41);
    tbl[15] = mk(1, 0, 0, 0, 8'h45, 5, 0, 0, 0, 0, 0, 0, 8'h77, 8'h41);
    tbl[16] = mk(1, 1, 1, 0, 8'h99, 0, 0, 1, 0, 1, 0, 0, 8'h77, 8'h00);
    tbl[17] = mk(0, 1, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h77, 8'h00);
    tbl[18] = mk(1, 0, 0, 0, 8'h5A, 1, 0, 0, 0, 1, 0, 0, 8'h77, 8'h5A);
    tbl[19] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h5A, 8'h00);

    #1;
    chk_all("reset", 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].enq, tbl[i].deq, tbl[i].fl, tbl[i].clr, tbl[i].din);
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].af,
              tbl[i].ae, tbl[i].ovf, tbl[i].unf, tbl[i].d0, tbl[i].d1);
    end

    // Fill to DEPTH with 0x00..0x0F.
    for (int i = 0; i < D; i++) begin
      cyc(1, 0, 0, 0, 8'(i));
      chk_all($sformatf("fill%0d", i), i + 1, (i + 1) == D, 0, (i + 1) >= 12, (i + 1) <= 2,
              0, 0, 8'h5A, 8'h00);
    end
    // Write when full is dropped and flagged.
    cyc(1, 0, 0, 0, 8'hAA);
    chk_all("ovf", 16, 1, 0, 1, 0, 1, 0, 8'h5A, 8'h00);
    cyc(0, 0, 0, 1, 8'h00);
    chk_all("ovf_clr", 16, 1, 0, 1, 0, 0, 0, 8'h5A, 8'h00);
    // Simultaneous push/pop at full: count holds, no overflow, write wraps.
    cyc(1, 1, 0, 0, 8'h55);
    chk_all("full_rw", 16, 1, 0, 1, 0, 0, 0, 8'h00, 8'h01);
    // Drain: 0x01..0x0F, then 0x55; 0xAA never appears.
    for (int k = 0; k < D; k++) begin
      logic [7:0] e0, e1;
      e0 = (k < 15) ? 8'(k + 1) : 8'h55;
      e1 = (k < 14) ? 8'(k + 2) : ((k == 14) ? 8'h55 : 8'h00);
      cyc(0, 1, 0, 0, 8'h00);
      chk_all($sformatf("drain%0d", k), 15 - k, 0, (15 - k) == 0, (15 - k) >= 12,
              (15 - k) <= 2, 0, 0, e0, e1);
    end

    // Set an error and build up 7 entries, then reset asynchronously.
    cyc(0, 1, 0, 0, 8'h00);
    chk_all("pre_unf", 0, 0, 1, 0, 1, 0, 1, 8'h55, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 8'(8'h60 + i));
    chk_all("pre_rst", 7, 0, 0, 0, 0, 0, 1, 8'h55, 8'h60);
    enqueue = 0; dequeue = 0; flush = 0; clear_err = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 8'hC3);
    chk_all("post_rst_wr", 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'hC3);
    cyc(0, 1, 0, 0, 8'h00);
    chk_all("post_rst_rd", 0, 0, 1, 0, 1, 0, 0, 8'hC3, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_queue_flags.md
PARAM_QUEUE_FLAGS -- requirements
Module: param_queue_flags

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, WIDTH >= 1.
REQ-002 Parameter DEPTH, default 16: storage entries, power of two, DEPTH >= 4.
REQ-003 Parameter AF_THRESH, default DEPTH-4: almost_full level, 1 <= AF_THRESH <= DEPTH.
REQ-004 Parameter AE_THRESH, default 2: almost_empty level, 0 <= AE_THRESH < DEPTH.
REQ-005 Parameter FWFT, default 0: read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  WIDTH  word to enqueue.
REQ-009 enqueue  input  1  write request.
REQ-010 dequeue  input  1  read/pop request.
REQ-011 flush  input  1  synchronous discard of all stored entries.
REQ-012 clear_err  input  1  synchronous clear of sticky error flags.
REQ-013 data_out  output  WIDTH  read data.
REQ-014 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  occupancy status.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Enqueue accepted when enqueue=1 and (count<DEPTH or an accepted dequeue occurs same cycle); data_in written at write pointer, pointer +1 modulo DEPTH.
REQ-018 Dequeue accepted when dequeue=1 and count>0; read pointer +1 modulo DEPTH.
REQ-019 count next = count + accepted_enq - accepted_deq; simultaneous accepted enqueue and dequeue leave count unchanged, including at count=DEPTH.
REQ-020 Enqueue with count=DEPTH and no dequeue: word dropped, storage and pointers unchanged, overflow set next edge.
REQ-021 Dequeue with count=0: ignored even if enqueue same cycle (enqueue still accepted), underflow set next edge.
REQ-022 Status derived from count, valid same cycle as count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH).
REQ-023 FWFT=0: on accepted dequeue, data_out loads head entry at that edge (1-cycle latency); otherwise data_out holds.
REQ-024 FWFT=1: data_out continuously equals head entry when count>0, 0 when count=0; accepted dequeue exposes next entry after the edge.
REQ-025 flush=1: next edge sets both pointers and count to 0; enqueue/dequeue that cycle ignored and raise no errors; data_out (FWFT=0) holds; overflow/underflow unchanged.
REQ-026 clear_err=1 clears overflow and underflow next edge; a new error in the same cycle wins (flag set).
REQ-027 Pointer wrap after DEPTH operations preserves strict FIFO order.
REQ-028 Storage contents are not reset; no entry read before written is ever visible on data_out.

Reset
REQ-029 rst_n=0 immediately, independent of clk: pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_THRESH... never 0), overflow=0, underflow=0.
REQ-030 Reset asserted mid-operation discards all stored entries; first accepted enqueue after release is the next word read.
REQ-031 Release of rst_n is synchronised by the bench to a falling clock edge; no operation accepted while rst_n=0.

Verification (WIDTH=8, DEPTH=16, AF_THRESH=12, AE_THRESH=2)
REQ-032 FWFT=0, enqueue 0x11,0x22,0x33 then dequeue 3 cycles -> data_out 0x11,0x22,0x33 one cycle after each pop; count 3->0; empty=1 at end.
REQ-033 Enqueue 16 words 0x00..0x0F, then enqueue 0xAA -> full=1, almost_full=1 from count 12, count=16, overflow=1, 0xAA never read; drain yields 0x00..0x0F.
REQ-034 At count=16, enqueue 0x55 with dequeue same cycle -> count stays 16, no overflow; 0x55 read last after 20 ops (pointer wrap checked).
REQ-035 Empty queue, dequeue=1 with enqueue 0x77 -> underflow=1, count=1; clear_err pulse -> underflow=0; FWFT=1 data_out=0x77 immediately.
REQ-036 Count=5, flush with enqueue 0x99 -> count=0, empty=1, no error; rst_n low mid-stream at count=7 -> all outputs per REQ-029 without a clock edge.
